// File: rtl/ula_sequential.sv
// ula_sequential: registered WIDTH-bit ALU with a valid/ready handshake.
// Single-cycle ops (ADD/SUB/AND/OR/XOR/illegal) are computed on the accept
// edge; MUL runs a shift-add loop, one multiplier bit per cycle, LSB first.
module ula_sequential #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [2:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] RESULT,
    output logic [WIDTH-1:0] RESULT_HI,
    output logic             CARRY,
    output logic             ZERO,
    output logic             NEG,
    output logic             OVF,
    output logic             ERR
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [2:0]       OP_ADD   = 3'b000;
    localparam logic [2:0]       OP_SUB   = 3'b001;
    localparam logic [2:0]       OP_AND   = 3'b010;
    localparam logic [2:0]       OP_OR    = 3'b011;
    localparam logic [2:0]       OP_XOR   = 3'b100;
    localparam logic [2:0]       OP_MUL   = 3'b101;
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(WIDTH - 1);

    state_t state, state_next;

    logic             accept;
    logic             step_last;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] hi_next;
    logic [WIDTH-1:0] lo_next;

    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [WIDTH-1:0] op_res;
    logic             op_carry;
    logic             op_ovf;
    logic             op_err;
    logic             op_zero;

    // Signed overflow: operands agree in sign but the sum does not.
    function automatic logic add_ovf(input logic am, input logic bm, input logic rm);
        return (am == bm) && (rm != am);
    endfunction

    // Signed overflow for A-B: operands differ in sign and result flips from A.
    function automatic logic sub_ovf(input logic am, input logic bm, input logic rm);
        return (am != bm) && (rm != am);
    endfunction

    assign IN_READY  = (state == IDLE);
    assign OUT_VALID = (state == DONE);
    assign accept    = IN_VALID && (state == IDLE);
    assign step_last = (state == BUSY) && (cnt == CNT_LAST);

    // One shift-add step: add multiplicand to the high half when the current
    // multiplier bit is set, then shift the whole {hi,lo} pair right by one.
    assign mul_sum = {1'b0, hi} + {1'b0, (lo[0] ? a_reg : {WIDTH{1'b0}})};
    assign hi_next = mul_sum[WIDTH:1];
    assign lo_next = {mul_sum[0], lo[WIDTH-1:1]};

    assign add_full = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, CIN};
    assign sub_full = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, CIN};

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (OP == OP_MUL) ? BUSY : DONE;
            BUSY: if (step_last) state_next = DONE;
            DONE: if (OUT_READY) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Single-cycle result and flags from the live operands (used on accept).
    always_comb begin
        op_res   = '0;
        op_carry = 1'b0;
        op_ovf   = 1'b0;
        op_err   = 1'b0;
        case (OP)
            OP_ADD: begin
                op_res   = add_full[WIDTH-1:0];
                op_carry = add_full[WIDTH];
                op_ovf   = add_ovf(A[WIDTH-1], B[WIDTH-1], add_full[WIDTH-1]);
            end
            OP_SUB: begin
                op_res   = sub_full[WIDTH-1:0];
                op_carry = sub_full[WIDTH];
                op_ovf   = sub_ovf(A[WIDTH-1], B[WIDTH-1], sub_full[WIDTH-1]);
            end
            OP_AND: op_res = A & B;
            OP_OR:  op_res = A | B;
            OP_XOR: op_res = A ^ B;
            OP_MUL: op_res = '0;
            default: op_err = 1'b1;
        endcase
        op_zero = op_err || (op_res == '0);
    end

    // Operand latch, multiply loop and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_reg     <= '0;
            hi        <= '0;
            lo        <= '0;
            cnt       <= '0;
            RESULT    <= '0;
            RESULT_HI <= '0;
            CARRY     <= 1'b0;
            ZERO      <= 1'b0;
            NEG       <= 1'b0;
            OVF       <= 1'b0;
            ERR       <= 1'b0;
        end else if (accept) begin
            a_reg <= A;
            hi    <= '0;
            lo    <= B;
            cnt   <= '0;
            if (OP != OP_MUL) begin
                RESULT    <= op_res;
                RESULT_HI <= '0;
                CARRY     <= op_carry;
                ZERO      <= op_zero;
                NEG       <= op_res[WIDTH-1];
                OVF       <= op_ovf;
                ERR       <= op_err;
            end
        end else if (state == BUSY) begin
            hi  <= hi_next;
            lo  <= lo_next;
            cnt <= cnt + 1'b1;
            if (step_last) begin
                RESULT    <= lo_next;
                RESULT_HI <= hi_next;
                CARRY     <= (hi_next != '0);
                ZERO      <= ({hi_next, lo_next} == '0);
                NEG       <= lo_next[WIDTH-1];
                OVF       <= 1'b0;
                ERR       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ula_sequential.sv
// Self-checking bench for ula_sequential (WIDTH=8): directed cases, random
// operations against an arithmetic reference model, backpressure and reset.
module tb_ula_sequential;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         IN_VALID = 1'b0;
    logic         IN_READY;
    logic [2:0]   OP = 3'b000;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         CIN = 1'b0;
    logic         OUT_VALID;
    logic         OUT_READY = 1'b0;
    logic [W-1:0] RESULT;
    logic [W-1:0] RESULT_HI;
    logic         CARRY, ZERO, NEG, OVF, ERR;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         c;
        logic         z;
        logic         n;
        logic         v;
        logic         e;
    } exp_t;

    ula_sequential #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OP(OP), .A(A), .B(B), .CIN(CIN), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .RESULT(RESULT), .RESULT_HI(RESULT_HI),
        .CARRY(CARRY), .ZERO(ZERO), .NEG(NEG), .OVF(OVF), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation definitions.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic cin);
        exp_t   r;
        longint m  = longint'(1) << W;
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = (ua >= m / 2) ? ua - m : ua;
        longint sb = (ub >= m / 2) ? ub - m : ub;
        longint t;
        longint st;
        r = '0;
        case (op)
            3'd0: begin
                t = ua + ub + cin;
                r.res = W'(t % m);
                r.c = (t >= m);
                st = sa + sb + cin;
                r.v = (st >= m / 2) || (st < -(m / 2));
            end
            3'd1: begin
                t = ua - ub - cin;
                r.res = W'((t + m) % m);
                r.c = (ua < ub + cin);
                st = sa - sb - cin;
                r.v = (st >= m / 2) || (st < -(m / 2));
            end
            3'd2: r.res = a & b;
            3'd3: r.res = a | b;
            3'd4: r.res = a ^ b;
            3'd5: begin
                t = ua * ub;
                r.res = W'(t % m);
                r.hi = W'(t / m);
                r.c = (t / m) != 0;
            end
            default: r.e = 1'b1;
        endcase
        if (op == 3'd5) r.z = (ua * ub) == 0;
        else            r.z = r.e || (r.res == '0);
        r.n = r.e ? 1'b0 : r.res[W-1];
        return r;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o.res = RESULT; o.hi = RESULT_HI; o.c = CARRY; o.z = ZERO;
        o.n = NEG; o.v = OVF; o.e = ERR;
        return o;
    endfunction

    // Issue one operation, check latency and outputs, hold backpressure for
    // 'hold' cycles with junk on the inputs, then release the result.
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic cin, input int hold);
        exp_t e;
        exp_t snap;
        int   lat;
        e = model(op, a, b, cin);
        @(negedge CLK);
        check("in_ready_idle", IN_READY, 1'b1);
        IN_VALID  = 1'b1;
        OP = op; A = a; B = b; CIN = cin;
        OUT_READY = 1'($urandom);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        A = W'($urandom); B = W'($urandom); CIN = 1'($urandom);
        OP = 3'($urandom);
        lat = 0;
        while (!OUT_VALID && lat < 100) begin
            OUT_READY = 1'($urandom);
            @(posedge CLK);
            #1;
            lat++;
        end
        OUT_READY = 1'b0;
        check("latency", lat, (op == 3'd5) ? W : 0);
        check("result", RESULT, e.res);
        check("result_hi", RESULT_HI, e.hi);
        check("flags", {CARRY, ZERO, NEG, OVF, ERR}, {e.c, e.z, e.n, e.v, e.e});
        snap = observed();
        for (int k = 0; k < hold; k++) begin
            IN_VALID = 1'b1;
            A = W'($urandom); B = W'($urandom); OP = 3'($urandom);
            @(posedge CLK);
            #1;
            check("hold_outputs", observed(), snap);
            check("hold_valid_ready", {OUT_VALID, IN_READY}, 2'b10);
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        check("release_valid_ready", {OUT_VALID, IN_READY}, 2'b01);
    endtask

    initial begin
        int seen;
        #1;
        check("reset_ready_valid", {IN_READY, OUT_VALID}, 2'b10);
        check("reset_outputs", {RESULT, RESULT_HI, CARRY, ZERO, NEG, OVF, ERR}, '0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        // Directed cases
        do_op(3'd0, 8'hFF, 8'h01, 1'b0, 0);
        do_op(3'd0, 8'h7F, 8'h01, 1'b0, 1);
        do_op(3'd1, 8'h10, 8'h20, 1'b1, 0);
        do_op(3'd1, 8'h80, 8'h01, 1'b0, 0);
        do_op(3'd2, 8'hF0, 8'h3C, 1'b1, 0);
        do_op(3'd3, 8'hF0, 8'h3C, 1'b0, 0);
        do_op(3'd4, 8'hF0, 8'h3C, 1'b1, 0);
        do_op(3'd5, 8'hFF, 8'hFF, 1'b0, 2);
        do_op(3'd5, 8'h00, 8'h5A, 1'b1, 0);
        do_op(3'd7, 8'hAA, 8'h55, 1'b1, 5);
        do_op(3'd6, 8'h01, 8'h02, 1'b0, 0);

        // Random operations
        for (int i = 0; i < 60; i++)
            do_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom),
                  1'($urandom), $urandom_range(0, 3));

        // Reset three cycles into a multiply
        do_op(3'd0, 8'h12, 8'h34, 1'b0, 0);
        @(negedge CLK);
        IN_VALID = 1'b1; OP = 3'd5; A = 8'hC3; B = 8'h7E; CIN = 1'b0;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        check("rst_async_ready_valid", {IN_READY, OUT_VALID}, 2'b10);
        check("rst_async_outputs", {RESULT, RESULT_HI, CARRY, ZERO, NEG, OVF, ERR}, '0);
        IN_VALID = 1'b1; OP = 3'd0; A = 8'h11; B = 8'h22;
        @(posedge CLK);
        #1;
        check("rst_ignores_valid", {IN_READY, OUT_VALID}, 2'b10);
        @(negedge CLK);
        IN_VALID = 1'b0;
        RST = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge CLK);
            #1;
            if (OUT_VALID) seen++;
        end
        check("no_valid_after_rst", seen, 0);
        do_op(3'd0, 8'h02, 8'h03, 1'b0, 0);
        check("fresh_add_result", RESULT, 8'h05);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
